// File: rtl/link_pkg.sv
// Shared types and default timing for the link bring-up sequencer.
package link_pkg;

    localparam int LINK_STATE_W = 3;

    typedef enum logic [LINK_STATE_W-1:0] {
        RST_PULSE = 3'd0,
        INIT_WAIT = 3'd1,
        LINK_IDLE = 3'd2,
        RUN       = 3'd3,
        FAILED    = 3'd4
    } link_state_e;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_RESET_PULSE   = 4;
    localparam int DEF_INIT_TIMEOUT  = 65536;
    localparam int DEF_SETTLE_CYCLES = 100;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_CNT_W         = 17;

    function automatic logic link_up(
        input logic tx_done,
        input logic rx_done,
        input logic sync_lost
    );
        return tx_done & rx_done & ~sync_lost;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Flop-chain synchroniser for one asynchronous status bit.
module sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic write_clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    generate
        if (SYNC_STAGES == 1) begin : g_one
            always_ff @(posedge write_clk) begin
                if (reset) chain <= '0;
                else       chain <= d;
            end
        end else begin : g_many
            always_ff @(posedge write_clk) begin
                if (reset) chain <= '0;
                else       chain <= {chain[SYNC_STAGES-2:0], d};
            end
        end
    endgenerate

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/link_sequencer.sv
// GTP link bring-up FSM: soft reset, init wait, settle on IDLE,
// then gated FIFO writes; retries on timeout, re-inits on link loss.
module link_sequencer
    import link_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int RESET_PULSE   = DEF_RESET_PULSE,
    parameter int INIT_TIMEOUT  = DEF_INIT_TIMEOUT,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                    write_clk,
    input  logic                    reset,
    input  logic                    txinit_done,
    input  logic                    rxinit_done,
    input  logic                    rx_sync_lost,
    input  logic                    we_req,
    input  logic                    fifo_full,
    output logic                    gtp_soft_reset,
    output logic                    link_ready,
    output logic                    we_out,
    output logic [LINK_STATE_W-1:0] link_state,
    output logic [1:0]              retry_cnt,
    output logic                    init_failed
);

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_PULSE - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STL_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

    logic tx_s;
    logic rx_s;
    logic lost_s;

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tx (
        .write_clk (write_clk),
        .reset     (reset),
        .d         (txinit_done),
        .q         (tx_s)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rx (
        .write_clk (write_clk),
        .reset     (reset),
        .d         (rxinit_done),
        .q         (rx_s)
    );

    sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lost (
        .write_clk (write_clk),
        .reset     (reset),
        .d         (rx_sync_lost),
        .q         (lost_s)
    );

    link_state_e      state;
    link_state_e      state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [1:0]       retry_nx;
    logic             cnt_zero;
    logic             up;

    assign cnt_zero = (cnt == '0);
    assign up       = link_up(tx_s, rx_s, lost_s);

    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        cnt_nx   = cnt_zero ? '0 : cnt - 1'b1;
        unique case (state)
            RST_PULSE: begin
                if (cnt_zero) begin
                    state_nx = INIT_WAIT;
                    cnt_nx   = TMO_LOAD;
                end
            end
            INIT_WAIT: begin
                // init done takes priority over a coincident timeout
                if (tx_s && rx_s) begin
                    state_nx = LINK_IDLE;
                    cnt_nx   = STL_LOAD;
                end else if (cnt_zero) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_nx = retry_cnt + 2'd1;
                        state_nx = RST_PULSE;
                        cnt_nx   = RST_LOAD;
                    end else begin
                        state_nx = FAILED;
                        cnt_nx   = '0;
                    end
                end
            end
            LINK_IDLE: begin
                if (!up) begin
                    state_nx = RST_PULSE;
                    cnt_nx   = RST_LOAD;
                end else if (cnt_zero) begin
                    state_nx = RUN;
                    retry_nx = 2'd0;
                    cnt_nx   = '0;
                end
            end
            RUN: begin
                if (!up) begin
                    state_nx = RST_PULSE;
                    cnt_nx   = RST_LOAD;
                end
            end
            FAILED: begin
                state_nx = FAILED;
            end
            default: begin
                state_nx = RST_PULSE;
                cnt_nx   = RST_LOAD;
            end
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (reset) begin
            state          <= RST_PULSE;
            cnt            <= RST_LOAD;
            retry_cnt      <= 2'd0;
            gtp_soft_reset <= 1'b1;
            link_ready     <= 1'b0;
            init_failed    <= 1'b0;
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            retry_cnt      <= retry_nx;
            gtp_soft_reset <= (state_nx == RST_PULSE);
            link_ready     <= (state_nx == LINK_IDLE) ||
                              (state_nx == RUN);
            init_failed    <= (state_nx == FAILED);
        end
    end

    // same-cycle gate so a full FIFO never sees a write
    assign we_out     = we_req & ~fifo_full & (state == RUN);
    assign link_state = state;

endmodule

// File: tb/tb_link_sequencer.sv
// Randomised bench for link_sequencer against a phase-level model.
module tb_link_sequencer;

    localparam int SS = 2;
    localparam int RP = 4;
    localparam int IT = 512;
    localparam int SC = 100;
    localparam int MR = 3;
    localparam int CW = 17;

    logic       write_clk = 1'b0;
    logic       reset = 1'b1;
    logic       txinit_done = 1'b0;
    logic       rxinit_done = 1'b0;
    logic       rx_sync_lost = 1'b0;
    logic       we_req = 1'b0;
    logic       fifo_full = 1'b0;
    logic       gtp_soft_reset;
    logic       link_ready;
    logic       we_out;
    logic [2:0] link_state;
    logic [1:0] retry_cnt;
    logic       init_failed;

    always #5 write_clk = ~write_clk;

    link_sequencer #(
        .SYNC_STAGES   (SS),
        .RESET_PULSE   (RP),
        .INIT_TIMEOUT  (IT),
        .SETTLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .CNT_W         (CW)
    ) dut (
        .write_clk      (write_clk),
        .reset          (reset),
        .txinit_done    (txinit_done),
        .rxinit_done    (rxinit_done),
        .rx_sync_lost   (rx_sync_lost),
        .we_req         (we_req),
        .fifo_full      (fifo_full),
        .gtp_soft_reset (gtp_soft_reset),
        .link_ready     (link_ready),
        .we_out         (we_out),
        .link_state     (link_state),
        .retry_cnt      (retry_cnt),
        .init_failed    (init_failed)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit rand_wr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         tag, got, exp, $time);
        end
    endtask

    // phase: 0 pulse, 1 wait, 2 idle, 3 run, 4 failed
    int m_phase;
    int m_left;
    int m_retry;
    bit qtx[$];
    bit qrx[$];
    bit qlost[$];

    task automatic model_reset();
        m_phase = 0;
        m_left  = RP - 1;
        m_retry = 0;
        qtx.delete();
        qrx.delete();
        qlost.delete();
        repeat (SS) begin
            qtx.push_back(1'b0);
            qrx.push_back(1'b0);
            qlost.push_back(1'b0);
        end
    endtask

    task automatic model_edge();
        bit stx;
        bit srx;
        bit slost;
        bit up;
        if (reset) begin
            model_reset();
            return;
        end
        stx   = qtx.pop_front();
        srx   = qrx.pop_front();
        slost = qlost.pop_front();
        qtx.push_back(txinit_done);
        qrx.push_back(rxinit_done);
        qlost.push_back(rx_sync_lost);
        up = stx && srx && !slost;
        case (m_phase)
            0: begin
                if (m_left == 0) begin
                    m_phase = 1;
                    m_left  = IT - 1;
                end else m_left--;
            end
            1: begin
                if (stx && srx) begin
                    m_phase = 2;
                    m_left  = SC - 1;
                end else if (m_left == 0) begin
                    if (m_retry < MR) begin
                        m_retry++;
                        m_phase = 0;
                        m_left  = RP - 1;
                    end else m_phase = 4;
                end else m_left--;
            end
            2, 3: begin
                if (!up) begin
                    m_phase = 0;
                    m_left  = RP - 1;
                end else if (m_phase == 2) begin
                    if (m_left == 0) begin
                        m_phase = 3;
                        m_retry = 0;
                    end else m_left--;
                end
            end
            default: ;
        endcase
    endtask

    task automatic step();
        if (rand_wr) begin
            we_req    = ($urandom_range(0, 3) != 0);
            fifo_full = ($urandom_range(0, 3) == 0);
        end
        #1;
        chk("state", link_state, m_phase);
        chk("soft_rst", gtp_soft_reset, m_phase == 0);
        chk("link_ready", link_ready, m_phase == 2 || m_phase == 3);
        chk("we_out", we_out, m_phase == 3 && we_req && !fifo_full);
        chk("retry", retry_cnt, m_retry);
        chk("failed", init_failed, m_phase == 4);
        @(posedge write_clk);
        model_edge();
        @(negedge write_clk);
    endtask

    task automatic run_until(input int ph, input int budget);
        int n = 0;
        while (m_phase != ph && n < budget) begin
            step();
            n++;
        end
        chk("reach_state", link_state, ph);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(posedge write_clk);
        model_edge();
        @(negedge write_clk);
        repeat (2) step();
        chk("rst_state", link_state, 0);
        chk("rst_soft", gtp_soft_reset, 1);
        chk("rst_ready", link_ready, 0);

        // normal bring-up: tx at cycle 10, rx at cycle 300
        reset = 1'b0;
        rand_wr = 1'b1;
        repeat (4) step();
        chk("pulse_end", gtp_soft_reset, 0);
        repeat (6) step();
        txinit_done = 1'b1;
        repeat (290) step();
        rxinit_done = 1'b1;
        repeat (2) step();
        chk("pre_idle", link_state, 1);
        step();
        chk("idle_entry", link_state, 2);
        repeat (SC - 1) step();
        chk("settle_block", we_out, 0);
        step();
        chk("run_entry", link_state, 3);
        repeat (100) step();

        // fifo_full gating with we_req held
        rand_wr = 1'b0;
        we_req  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            fifo_full = ((i / 3) % 2) == 1;
            #1;
            chk("full_gate", we_out, !fifo_full);
            step();
        end

        // single-cycle rx drop in RUN
        rand_wr = 1'b1;
        rxinit_done = 1'b0;
        step();
        rxinit_done = 1'b1;
        step();
        chk("loss_hold", link_ready, 1);
        step();
        chk("loss_ready", link_ready, 0);
        chk("loss_pulse", gtp_soft_reset, 1);
        run_until(3, 400);
        chk("loss_retry", retry_cnt, 0);

        // random sync-loss glitches
        for (int i = 0; i < 600; i++) begin
            rx_sync_lost = ($urandom_range(0, 150) == 0);
            step();
        end
        rx_sync_lost = 1'b0;
        run_until(3, 400);

        // reset during LINK_IDLE
        rxinit_done = 1'b0;
        step();
        rxinit_done = 1'b1;
        run_until(2, 400);
        repeat (20) step();
        reset = 1'b1;
        repeat (3) step();
        chk("midrst_state", link_state, 0);
        chk("midrst_ready", link_ready, 0);
        reset = 1'b0;
        run_until(3, 400);

        // init timeout with rx held low -> FAILED
        reset = 1'b1;
        rxinit_done = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        run_until(4, 4 * (IT + RP) + 50);
        chk("fail_state", link_state, 4);
        chk("fail_flag", init_failed, 1);
        chk("fail_retry", retry_cnt, 3);
        chk("fail_soft", gtp_soft_reset, 0);
        rxinit_done = 1'b1;
        repeat (20) step();
        chk("fail_sticky", init_failed, 1);

        // reset out of FAILED
        reset = 1'b1;
        repeat (3) step();
        chk("frst_flag", init_failed, 0);
        chk("frst_soft", gtp_soft_reset, 1);
        reset = 1'b0;
        run_until(3, 400);

        // rx done arrives on the same edge as the timeout
        reset = 1'b1;
        rxinit_done = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        for (int n = 0; n < 2 * (IT + RP) + 20; n++) begin
            if (m_phase == 1 && m_retry == 1 && m_left == SS) break;
            step();
        end
        rxinit_done = 1'b1;
        repeat (SS + 1) step();
        chk("sim_state", link_state, 2);
        chk("sim_retry", retry_cnt, 1);
        run_until(3, 400);
        chk("sim_clear", retry_cnt, 0);
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
